prpg_batch_sequencer: RTL and testbench

//  Batch controller for the 8-bit pattern generators (LFSR and 3-neighbour CA), replacing per-pattern run/store instruction sequences.
//  On start it latches the configuration, seeds the selected generator, then steps it COUNT times.

---
 rtl/prpg_batch_sequencer.sv | 137 +++++++++++++
 tb/tb_prpg_batch_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/prpg_batch_sequencer.sv
// prpg_batch_sequencer
//   Batch controller for the 8-bit pattern generators (LFSR / 3-neighbour CA).
//   A start in IDLE latches the configuration and seeds the generator. The
//   generator is then stepped COUNT times, and each new pattern is written to
//   consecutive pattern-memory addresses. The block also accumulates the
//   Hamming distance between successive patterns.
// Ports
//   clk, rst        clock, async active-high reset
//   start, abort    batch request (IDLE only) / synchronous cancel (non-IDLE)
//   mode            0 = LFSR, 1 = CA
//   tap, rule, seed generator config (latched at start)
//   base_addr,count first write address / number of patterns (latched)
//   mem_we/addr/wdata  pattern-memory write port (valid in STORE)
//   pattern         current generator state
//   total_hd        accumulated Hamming distance
//   busy, done      non-IDLE flag / one-cycle completion pulse
module prpg_batch_sequencer #(
  parameter int W      = 8,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [W-2:0]      tap,
  input  logic [W-1:0]      rule,
  input  logic [W-1:0]      seed,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [W-1:0]      mem_wdata,
  output logic [W-1:0]      pattern,
  output logic [10:0]       total_hd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, GEN, STORE, DONE} state_t;

  state_t            state, state_nx;
  logic              mode_q;
  logic [W-2:0]      tap_q;
  logic [W-1:0]      rule_q;
  logic [W-1:0]      gen;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  remaining;
  logic [10:0]       hd_acc;

  logic [W-1:0]      gen_nx;
  logic [W-1:0]      gen_diff;
  logic [3:0]        step_hd;

  // One generator step from the current state.
  always_comb begin
    gen_nx = '0;
    if (!mode_q) begin
      // Galois-style LFSR: the top stage feeds stage 0 and the tapped stages.
      gen_nx[0] = gen[W-1];
      for (int i = 1; i < W; i++)
        gen_nx[i] = gen[i-1] ^ (tap_q[W-1-i] & gen[W-1]);
    end else begin
      // Ring CA: neighbourhood {right, self, left} indexes the rule table.
      for (int i = 0; i < W; i++)
        gen_nx[i] = rule_q[{gen[(i+1)%W], gen[i], gen[(i+W-1)%W]}];
    end
  end

  always_comb begin
    gen_diff = gen ^ gen_nx;
    step_hd  = '0;
    for (int i = 0; i < W; i++)
      step_hd = step_hd + 4'(gen_diff[i]);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start) state_nx = (count == '0) ? DONE : GEN;
      GEN:   state_nx = abort ? IDLE : STORE;
      STORE: state_nx = abort ? IDLE : ((remaining == CNT_W'(1)) ? DONE : GEN);
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath. Abort suppresses every update, so pattern/total_hd hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      tap_q     <= '0;
      rule_q    <= '0;
      gen       <= '0;
      addr      <= '0;
      remaining <= '0;
      hd_acc    <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q    <= mode;
          tap_q     <= tap;
          rule_q    <= rule;
          gen       <= seed;
          addr      <= base_addr;
          remaining <= count;
          hd_acc    <= '0;
        end
        GEN: if (!abort) begin
          gen    <= gen_nx;
          hd_acc <= hd_acc + {7'd0, step_hd};
        end
        STORE: if (!abort) begin
          addr      <= addr + ADDR_W'(1);
          remaining <= remaining - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_we    = (state == STORE);
  assign mem_addr  = mem_we ? addr : '0;
  assign mem_wdata = mem_we ? gen  : '0;
  assign pattern   = gen;
  assign total_hd  = hd_acc;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_prpg_batch_sequencer.sv
module tb_prpg_batch_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [6:0] tap = '0;
  logic [7:0] rule = '0, seed = '0, base_addr = '0, count = '0;
  logic       mem_we, busy, done;
  logic [7:0] mem_addr, mem_wdata, pattern;
  logic [10:0] total_hd;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];   // {addr, data} of expected writes

  prpg_batch_sequencer #(.W(8), .ADDR_W(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .tap(tap), .rule(rule), .seed(seed), .base_addr(base_addr), .count(count),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .pattern(pattern), .total_hd(total_hd), .busy(busy), .done(done)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] step(input logic md, input logic [6:0] tp,
                                      input logic [7:0] rl, input logic [7:0] g);
    logic [7:0] n;
    logic [2:0] idx;
    n = '0;
    if (!md) begin
      n[0] = g[7];
      for (int i = 1; i < 8; i++) n[i] = g[i-1] ^ (tp[7-i] & g[7]);
    end else begin
      for (int i = 0; i < 8; i++) begin
        idx  = {g[(i+1)%8], g[i], g[(i+7)%8]};
        n[i] = rl[idx];
      end
    end
    return n;
  endfunction

  function automatic int popc(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  // Scoreboard: every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      if (exp_q.size() == 0) chk("unexp_wr", 32'(mem_addr), 32'hFFFF);
      else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[15:8]));
        chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end

  // Model a batch: pushes expected writes, returns final pattern and HD.
  task automatic model(input logic md, input logic [6:0] tp, input logic [7:0] rl,
                       input logic [7:0] sd, input logic [7:0] ba, input int cn,
                       output logic [7:0] g_out, output int hd_out);
    logic [7:0] g, nx, a;
    g = sd; a = ba; hd_out = 0;
    for (int j = 0; j < cn; j++) begin
      nx = step(md, tp, rl, g);
      hd_out += popc(g ^ nx);
      g = nx;
      exp_q.push_back({a, g});
      a = a + 8'd1;
    end
    g_out = g;
  endtask

  task automatic drive_start(input logic md, input logic [6:0] tp, input logic [7:0] rl,
                             input logic [7:0] sd, input logic [7:0] ba, input logic [7:0] cn,
                             input logic ab);
    @(negedge clk);
    mode = md; tap = tp; rule = rl; seed = sd; base_addr = ba; count = cn;
    start = 1'b1; abort = ab;
    @(negedge clk);   // cycle after E0
    start = 1'b0; abort = 1'b0;
    // Config may change freely once latched.
    mode = ~md; tap = ~tp; rule = ~rl; seed = 8'($urandom); base_addr = 8'($urandom);
    count = 8'($urandom);
  endtask

  // Full batch; exp_hd < 0 means only the model value is checked.
  task automatic run_batch(input string nm, input logic md, input logic [6:0] tp,
                           input logic [7:0] rl, input logic [7:0] sd, input logic [7:0] ba,
                           input int cn, input int exp_hd, input bit pester, input bit ab);
    logic [7:0] g_end;
    int hd;
    model(md, tp, rl, sd, ba, cn, g_end, hd);
    drive_start(md, tp, rl, sd, ba, 8'(cn), ab);
    for (int k = 0; k <= 2*cn + 3; k++) begin
      chk({nm, "_done"}, 32'(done), 32'(k == 2*cn));
      chk({nm, "_busy"}, 32'(busy), 32'(k <= 2*cn));
      if (pester && k == 2) begin
        start = 1'b1; seed = ~sd; count = 8'(cn + 5); base_addr = ba + 8'h40;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({nm, "_hd_model"}, 32'(total_hd), 32'(hd));
    if (exp_hd >= 0) chk({nm, "_hd_spec"}, 32'(total_hd), 32'(exp_hd));
    chk({nm, "_pattern"}, 32'(pattern), 32'(g_end));
    chk({nm, "_q_empty"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] g1;
    int hd1;

    #12;
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_busy",  32'(busy),     32'd0);
    chk("rst_done",  32'(done),     32'd0);
    chk("rst_hd",    32'(total_hd), 32'd0);
    chk("rst_pat",   32'(pattern),  32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    @(negedge clk); rst = 1'b0;

    // Spec vectors
    run_batch("t1", 1'b0, 7'd0,        8'h00, 8'h01, 8'h10, 3, 6, 1'b0, 1'b0);
    run_batch("t2", 1'b0, 7'b1000000,  8'h00, 8'h80, 8'hFF, 2, 5, 1'b0, 1'b0);
    run_batch("t3", 1'b1, 7'd0,        8'h5A, 8'h01, 8'h00, 2, 7, 1'b0, 1'b0);
    run_batch("t4", 1'b0, 7'h55,       8'h00, 8'h33, 8'h20, 0, 0, 1'b0, 1'b0);
    // Start while busy is ignored; start+abort in IDLE: start wins.
    run_batch("t5", 1'b0, 7'd0,        8'h00, 8'h01, 8'h10, 3, 6, 1'b1, 1'b1);
    // Zero LFSR seed, then a few random batches.
    run_batch("zs", 1'b0, 7'h7F,       8'h00, 8'h00, 8'hFE, 4, 0, 1'b0, 1'b0);
    for (int r = 0; r < 4; r++)
      run_batch("rnd", 1'(r), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                int'($urandom_range(1, 9)), -1, 1'b0, 1'b0);

    // Abort after the first write.
    model(1'b0, 7'h1D, 8'h00, 8'hC3, 8'h30, 1, g1, hd1);
    drive_start(1'b0, 7'h1D, 8'h00, 8'hC3, 8'h30, 8'd4, 1'b0);
    @(negedge clk);                       // STORE, first write
    chk("ab_we", 32'(mem_we), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_we_lo", 32'(mem_we), 32'd0);
    for (int k = 0; k < 6; k++) begin
      chk("ab_nodone", 32'(done | mem_we), 32'd0);
      @(negedge clk);
    end
    chk("ab_hd",  32'(total_hd), 32'(hd1));
    chk("ab_pat", 32'(pattern),  32'(g1));
    chk("ab_q",   32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // Async reset mid-STORE.
    model(1'b1, 7'd0, 8'h96, 8'h5C, 8'h80, 1, g1, hd1);
    drive_start(1'b1, 7'd0, 8'h96, 8'h5C, 8'h80, 8'd5, 1'b0);
    @(negedge clk);                       // STORE
    chk("rs_we_pre", 32'(mem_we), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rs_we",   32'(mem_we),   32'd0);
    chk("rs_busy", 32'(busy),     32'd0);
    chk("rs_hd",   32'(total_hd), 32'd0);
    chk("rs_pat",  32'(pattern),  32'd0);
    exp_q.delete();
    @(negedge clk); rst = 1'b0;
    run_batch("t6", 1'b0, 7'd0, 8'h00, 8'h01, 8'h10, 3, 6, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
